// File: rtl/pr_elastic_stage.sv
// Elastic pipeline register with a 2-entry skid buffer and a registered IN_READY.
// MAIN drives the outputs and SKID catches the one entry accepted while downstream stalls.
module pr_elastic_stage #(
   parameter int unsigned DATA_WIDTH = 96,
   parameter int unsigned CTRL_WIDTH = 15
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic [CTRL_WIDTH-1:0] IN_CTRL,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic [CTRL_WIDTH-1:0] OUT_CTRL,
   output logic [1:0]            OCCUPANCY
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_main_data, w_main_data_nxt;
   logic [CTRL_WIDTH-1:0] r_main_ctrl, w_main_ctrl_nxt;
   logic [DATA_WIDTH-1:0] r_skid_data, w_skid_data_nxt;
   logic [CTRL_WIDTH-1:0] r_skid_ctrl, w_skid_ctrl_nxt;

   // State register; handshake flags are registered copies of the next-state decode.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_SKID);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (FLUSH) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: if (IN_VALID) w_state_nxt = ST_FULL;
            ST_FULL: begin
               if (OUT_READY && !IN_VALID)      w_state_nxt = ST_EMPTY;
               else if (!OUT_READY && IN_VALID) w_state_nxt = ST_SKID;
            end
            ST_SKID: if (OUT_READY) w_state_nxt = ST_FULL;
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // MAIN is zeroed whenever it drains so a bubble never carries a live write enable.
   always_comb begin
      w_main_data_nxt = r_main_data;
      w_main_ctrl_nxt = r_main_ctrl;
      w_skid_data_nxt = r_skid_data;
      w_skid_ctrl_nxt = r_skid_ctrl;
      if (FLUSH) begin
         w_main_data_nxt = '0;
         w_main_ctrl_nxt = '0;
         w_skid_data_nxt = '0;
         w_skid_ctrl_nxt = '0;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (IN_VALID) begin
                  w_main_data_nxt = IN_DATA;
                  w_main_ctrl_nxt = IN_CTRL;
               end
            end
            ST_FULL: begin
               if (OUT_READY && IN_VALID) begin
                  w_main_data_nxt = IN_DATA;
                  w_main_ctrl_nxt = IN_CTRL;
               end else if (OUT_READY) begin
                  w_main_data_nxt = '0;
                  w_main_ctrl_nxt = '0;
               end else if (IN_VALID) begin
                  w_skid_data_nxt = IN_DATA;
                  w_skid_ctrl_nxt = IN_CTRL;
               end
            end
            ST_SKID: begin
               if (OUT_READY) begin
                  w_main_data_nxt = r_skid_data;
                  w_main_ctrl_nxt = r_skid_ctrl;
                  w_skid_data_nxt = '0;
                  w_skid_ctrl_nxt = '0;
               end
            end
            default: begin
               w_main_data_nxt = '0;
               w_main_ctrl_nxt = '0;
               w_skid_data_nxt = '0;
               w_skid_ctrl_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         r_main_data <= w_main_data_nxt;
         r_main_ctrl <= w_main_ctrl_nxt;
         r_skid_data <= w_skid_data_nxt;
         r_skid_ctrl <= w_skid_ctrl_nxt;
      end
   end

   assign IN_READY  = r_in_ready;
   assign OUT_VALID = r_out_valid;
   assign OUT_DATA  = r_main_data;
   assign OUT_CTRL  = r_main_ctrl;
   assign OCCUPANCY = r_state;

endmodule

// File: tb/tb_pr_elastic_stage.sv
// Directed bench for pr_elastic_stage: reset, streaming, skid, stall hold, flush and bubbles.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_pr_elastic_stage;

   localparam int unsigned DW = 96;
   localparam int unsigned CW = 15;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          FLUSH;
   logic          IN_VALID;
   logic          IN_READY;
   logic [DW-1:0] IN_DATA;
   logic [CW-1:0] IN_CTRL;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [DW-1:0] OUT_DATA;
   logic [CW-1:0] OUT_CTRL;
   logic [1:0]    OCCUPANCY;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   pr_elastic_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL),
      .OCCUPANCY(OCCUPANCY)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
      IN_VALID  = v;
      IN_DATA   = d;
      IN_CTRL   = c;
      OUT_READY = ordy;
   endtask

   task automatic test_reset();
      RESET = 1'b0; FLUSH = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      step();
      checks++;
      if ({OUT_VALID, IN_READY, OCCUPANCY, OUT_CTRL} !== {1'b0, 1'b1, 2'd0, 15'd0} || OUT_DATA !== '0) begin
         failures++;
         $display("FAIL reset_initial: valid=%0b rdy=%0b occ=%0d ctrl=%h data=%h, want 0/1/0/0/0",
                  OUT_VALID, IN_READY, OCCUPANCY, OUT_CTRL, OUT_DATA);
      end
      RESET = 1'b1;
      step();
      // Fill both entries, then pull reset mid-cycle.
      drive(1'b1, 96'h11, 15'h7, 1'b0); step();
      drive(1'b1, 96'h22, 15'h3, 1'b0); step();
      checks++;
      if (OCCUPANCY !== 2'd2) begin
         failures++; $display("FAIL reset_prefill_occ: got %0d want 2", OCCUPANCY);
      end
      #2 RESET = 1'b0;
      #1;
      checks++;
      if ({OUT_VALID, IN_READY, OCCUPANCY, OUT_CTRL} !== {1'b0, 1'b1, 2'd0, 15'd0} || OUT_DATA !== '0) begin
         failures++;
         $display("FAIL reset_async: valid=%0b rdy=%0b occ=%0d ctrl=%h data=%h, want 0/1/0/0/0",
                  OUT_VALID, IN_READY, OCCUPANCY, OUT_CTRL, OUT_DATA);
      end
      drive(1'b0, '0, '0, 1'b0);
      step();
      RESET = 1'b1;
      step();
   endtask

   task automatic test_streaming();
      logic [DW-1:0] exp_d;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, DW'(i), CW'(i + 8), 1'b1);
         step();
         exp_d = DW'(i);
         checks++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_d || OUT_CTRL !== CW'(i + 8) || OCCUPANCY !== 2'd1) begin
            failures++;
            $display("FAIL stream_%0d: valid=%0b data=%h ctrl=%h occ=%0d, want 1/%h/%h/1",
                     i, OUT_VALID, OUT_DATA, OUT_CTRL, OCCUPANCY, exp_d, CW'(i + 8));
         end
      end
      // Drain the last entry with no new input: a zeroed bubble must follow.
      drive(1'b0, 96'hDEAD, 15'h7FFF, 1'b1);
      step();
      checks++;
      if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OUT_DATA !== '0 || OCCUPANCY !== 2'd0) begin
         failures++;
         $display("FAIL bubble_after_stream: valid=%0b ctrl=%h data=%h occ=%0d, want 0/0/0/0",
                  OUT_VALID, OUT_CTRL, OUT_DATA, OCCUPANCY);
      end
   endtask

   task automatic test_skid();
      drive(1'b1, 96'hA, 15'h0A, 1'b1); step();
      drive(1'b1, 96'hB, 15'h0B, 1'b0); step();
      checks++;
      if (OCCUPANCY !== 2'd2 || IN_READY !== 1'b0 || OUT_DATA !== 96'hA) begin
         failures++;
         $display("FAIL skid_enter: occ=%0d rdy=%0b data=%h, want 2/0/a", OCCUPANCY, IN_READY, OUT_DATA);
      end
      drive(1'b1, 96'hC, 15'h0C, 1'b0); step();
      checks++;
      if (OCCUPANCY !== 2'd2 || OUT_DATA !== 96'hA || OUT_CTRL !== 15'h0A) begin
         failures++;
         $display("FAIL skid_hold: occ=%0d data=%h ctrl=%h, want 2/a/a", OCCUPANCY, OUT_DATA, OUT_CTRL);
      end
      drive(1'b1, 96'hC, 15'h0C, 1'b1); step();
      checks++;
      if (OUT_DATA !== 96'hB || OUT_CTRL !== 15'h0B || OCCUPANCY !== 2'd1 || IN_READY !== 1'b1) begin
         failures++;
         $display("FAIL skid_drain_b: data=%h ctrl=%h occ=%0d rdy=%0b, want b/b/1/1",
                  OUT_DATA, OUT_CTRL, OCCUPANCY, IN_READY);
      end
      step();
      checks++;
      if (OUT_DATA !== 96'hC || OUT_CTRL !== 15'h0C || OUT_VALID !== 1'b1) begin
         failures++;
         $display("FAIL skid_then_c: data=%h ctrl=%h valid=%0b, want c/c/1", OUT_DATA, OUT_CTRL, OUT_VALID);
      end
      drive(1'b0, '0, '0, 1'b1); step();
      checks++;
      if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OCCUPANCY !== 2'd0) begin
         failures++;
         $display("FAIL skid_empty: valid=%0b ctrl=%h occ=%0d, want 0/0/0", OUT_VALID, OUT_CTRL, OCCUPANCY);
      end
   endtask

   task automatic test_stall_hold();
      int unsigned seen;
      drive(1'b1, 96'h55, 15'h1F, 1'b0); step();
      drive(1'b0, 96'h66, 15'h2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (OUT_VALID !== 1'b1 || OUT_CTRL !== 15'h1F || OUT_DATA !== 96'h55 || OCCUPANCY !== 2'd1) begin
            failures++;
            $display("FAIL stall_hold_%0d: valid=%0b ctrl=%h data=%h occ=%0d, want 1/1f/55/1",
                     i, OUT_VALID, OUT_CTRL, OUT_DATA, OCCUPANCY);
         end
         step();
      end
      // Release: exactly one transfer of 0x55 should occur, then empty.
      seen = 0;
      OUT_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         if (OUT_VALID && OUT_READY) seen++;
         #1;
      end
      checks++;
      if (seen != 1 || OUT_VALID !== 1'b0 || OCCUPANCY !== 2'd0) begin
         failures++;
         $display("FAIL stall_release: transfers=%0d valid=%0b occ=%0d, want 1/0/0", seen, OUT_VALID, OCCUPANCY);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 96'h1, 15'h11, 1'b0); step();
      drive(1'b1, 96'h2, 15'h12, 1'b0); step();
      checks++;
      if (OCCUPANCY !== 2'd2) begin
         failures++; $display("FAIL flush_prefill: occ=%0d want 2", OCCUPANCY);
      end
      // Flush coincides with a skid drain (OUT_READY=1) and a new offered input.
      FLUSH = 1'b1;
      drive(1'b1, 96'h3, 15'h13, 1'b1); step();
      FLUSH = 1'b0;
      checks++;
      if ({OUT_VALID, IN_READY, OCCUPANCY, OUT_CTRL} !== {1'b0, 1'b1, 2'd0, 15'd0} || OUT_DATA !== '0) begin
         failures++;
         $display("FAIL flush: valid=%0b rdy=%0b occ=%0d ctrl=%h data=%h, want 0/1/0/0/0",
                  OUT_VALID, IN_READY, OCCUPANCY, OUT_CTRL, OUT_DATA);
      end
      drive(1'b0, '0, '0, 1'b1); step();
      checks++;
      if (OUT_VALID !== 1'b0 || OCCUPANCY !== 2'd0 || OUT_DATA !== '0) begin
         failures++;
         $display("FAIL flush_dropped_input: valid=%0b occ=%0d data=%h, want 0/0/0", OUT_VALID, OCCUPANCY, OUT_DATA);
      end
   endtask

   task automatic test_back_to_back();
      // Accept from EMPTY, then stall-free refill: 0x77 in, 0x88 in behind it.
      drive(1'b1, 96'h77, 15'h7, 1'b1); step();
      drive(1'b1, 96'h88, 15'h8, 1'b1); step();
      checks++;
      if (OUT_DATA !== 96'h88 || OUT_CTRL !== 15'h8 || OCCUPANCY !== 2'd1) begin
         failures++;
         $display("FAIL b2b: data=%h ctrl=%h occ=%0d, want 88/8/1", OUT_DATA, OUT_CTRL, OCCUPANCY);
      end
      drive(1'b0, '0, '0, 1'b1); step();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_skid();
      test_stall_hold();
      test_flush();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
